// File: rtl/custom_ip_reg_sched_if.sv
// Register-channel bundle shared by the requesters, the scheduler and the IP.
// master drives requests and IP status; slave is the scheduler's view.
interface custom_ip_reg_sched_if #(
  parameter int NREQ = 3,
  parameter int NREG = 6,
  parameter int DW   = 32,
  parameter int IDXW = 3
) ();

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ-1:0]      req_we_i;
  logic [NREQ*IDXW-1:0] req_idx_i;
  logic [NREQ*DW-1:0]   req_wdata_i;

  logic [NREQ-1:0]      rsp_valid_o;
  logic [DW-1:0]        rsp_rdata_o;
  logic                 rsp_err_o;

  logic [NREG-1:0]      ip_wen_o;
  logic [DW-1:0]        ip_wdata_o;
  logic [NREG-1:0]      ip_wack_i;
  logic [NREG*DW-1:0]   ip_rdata_i;
  logic [NREG-1:0]      ip_rvalid_i;

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_idx_i,
    output req_wdata_i,
    output ip_wack_i,
    output ip_rdata_i,
    output ip_rvalid_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_rdata_o,
    input  rsp_err_o,
    input  ip_wen_o,
    input  ip_wdata_o
  );

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_idx_i,
    input  req_wdata_i,
    input  ip_wack_i,
    input  ip_rdata_i,
    input  ip_rvalid_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_rdata_o,
    output rsp_err_o,
    output ip_wen_o,
    output ip_wdata_o
  );

endinterface

// File: rtl/custom_ip_reg_sched.sv
// Round-robin scheduler serialising register accesses to a custom IP.
// Define CUSTOM_IP_SCHED_STATS_EN to add busy-cycle and timeout counters.
module custom_ip_reg_sched #(
  parameter int NREQ    = 3,
  parameter int NREG    = 6,
  parameter int DW      = 32,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  custom_ip_reg_sched_if.slave bus
`ifdef CUSTOM_IP_SCHED_STATS_EN
  ,
  output logic [31:0] stat_busy_o,
  output logic [15:0] stat_timeout_o
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [PW-1:0]   id;
    logic            we;
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   wdata;
  } txn_t;

  state_t        state_q, state_d;
  txn_t          txn_q, txn_d, cand;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          any_req;
  logic [PW-1:0] winner;

  logic            idx_ok;
  logic [NREG-1:0] idx_oh;
  logic            hit_ack;
  logic            hit_rvalid;
  logic [DW-1:0]   hit_rdata;
  logic            done;
  logic            expire;

  function automatic logic [PW-1:0] rr_pick(
    input logic [PW-1:0] base,
    input int            k
  );
    int r;
    r = int'(base) + k;
    if (r >= NREQ) r = r - NREQ;
    return PW'(r);
  endfunction

  // first valid requester at or after the pointer, with wrap
  always_comb begin
    logic [PW-1:0] sel;
    sel     = '0;
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = rr_pick(ptr_q, k);
      if (!any_req && bus.req_valid_i[sel]) begin
        any_req = 1'b1;
        winner  = sel;
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (winner == PW'(r)) begin
        cand.id    = winner;
        cand.we    = bus.req_we_i[r];
        cand.idx   = bus.req_idx_i[r*IDXW +: IDXW];
        cand.wdata = bus.req_wdata_i[r*DW +: DW];
      end
    end
  end

  // only the latched index's ack/valid/data are looked at
  always_comb begin
    idx_ok     = 1'b0;
    idx_oh     = '0;
    hit_ack    = 1'b0;
    hit_rvalid = 1'b0;
    hit_rdata  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (txn_q.idx == IDXW'(i)) begin
        idx_ok     = 1'b1;
        idx_oh[i]  = 1'b1;
        hit_ack    = bus.ip_wack_i[i];
        hit_rvalid = bus.ip_rvalid_i[i];
        hit_rdata  = bus.ip_rdata_i[i*DW +: DW];
      end
    end
  end

  assign done   = txn_q.we ? hit_ack : hit_rvalid;
  assign expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.rsp_rdata_o = '0;
    bus.rsp_err_o   = 1'b0;
    bus.ip_wen_o    = '0;
    bus.ip_wdata_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          bus.req_ready_o[winner] = 1'b1;
          txn_d   = cand;
          ptr_d   = (winner == PTR_LAST) ? '0 : winner + 1'b1;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (!idx_ok) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          if (txn_q.we) begin
            bus.ip_wen_o   = idx_oh;
            bus.ip_wdata_o = txn_q.wdata;
          end
          if (done) begin
            rdata_d = txn_q.we ? '0 : hit_rdata;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (txn_q.we) bus.ip_wdata_o = txn_q.wdata;
        // a late ack landing on the expiry cycle still counts
        if (done) begin
          rdata_d = txn_q.we ? '0 : hit_rdata;
          state_d = RESP;
        end else if (expire) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        bus.rsp_valid_o[txn_q.id] = 1'b1;
        bus.rsp_rdata_o = rdata_q;
        bus.rsp_err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      txn_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef CUSTOM_IP_SCHED_STATS_EN
  logic timeout_hit;

  assign timeout_hit = (state_q == WAIT) && !done && expire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_busy_o    <= '0;
      stat_timeout_o <= '0;
    end else begin
      if (state_q != IDLE && stat_busy_o != '1)
        stat_busy_o <= stat_busy_o + 1'b1;
      if (timeout_hit && stat_timeout_o != '1)
        stat_timeout_o <= stat_timeout_o + 1'b1;
    end
  end
`endif

  a_ready_onehot: assert property (
    @(posedge clk_i) $onehot0(bus.req_ready_o));
  a_rsp_onehot: assert property (
    @(posedge clk_i) $onehot0(bus.rsp_valid_o));
  a_wen_onehot: assert property (
    @(posedge clk_i) $onehot0(bus.ip_wen_o));

endmodule

// File: tb/tb_custom_ip_reg_sched.sv
// Randomised bench for custom_ip_reg_sched against a transaction-level model.
// Model tracks rr pointer and derives grant, latency, data and error per access.
module tb_custom_ip_reg_sched;

  localparam int NREQ    = 3;
  localparam int NREG    = 6;
  localparam int DW      = 32;
  localparam int IDXW    = 3;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst_i;

  custom_ip_reg_sched_if #(
    .NREQ(NREQ), .NREG(NREG), .DW(DW), .IDXW(IDXW)
  ) bus ();

`ifdef CUSTOM_IP_SCHED_STATS_EN
  logic [31:0] stat_busy;
  logic [15:0] stat_timeout;
`endif

  custom_ip_reg_sched #(
    .NREQ(NREQ), .NREG(NREG), .DW(DW),
    .IDXW(IDXW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus(bus)
`ifdef CUSTOM_IP_SCHED_STATS_EN
    ,
    .stat_busy_o(stat_busy),
    .stat_timeout_o(stat_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [NREQ-1:0] pend_v;
  logic            pend_we [NREQ];
  logic [IDXW-1:0] pend_idx[NREQ];
  logic [DW-1:0]   pend_wd [NREQ];
  logic [DW-1:0]   ipd     [NREG];
  int              ptr_m;

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < NREQ; r++) begin
      bus.req_valid_i[r] = pend_v[r];
      bus.req_we_i[r] = pend_we[r];
      bus.req_idx_i[r*IDXW +: IDXW] = pend_idx[r];
      bus.req_wdata_i[r*DW +: DW] = pend_wd[r];
    end
  endtask

  // target index follows `hit`; every other status bit is noise
  task automatic drive_ip(input int idx, input bit we, input bit hit);
    for (int i = 0; i < NREG; i++) begin
      bus.ip_wack_i[i] = 1'($urandom);
      bus.ip_rvalid_i[i] = 1'($urandom);
      if (i == idx) begin
        if (we) bus.ip_wack_i[i] = hit;
        else bus.ip_rvalid_i[i] = hit;
      end
      bus.ip_rdata_i[i*DW +: DW] = ipd[i];
    end
  endtask

  task automatic regen(input int r);
    pend_v[r] = ($urandom_range(3, 0) != 0);
    pend_we[r] = 1'($urandom);
    pend_idx[r] = IDXW'($urandom_range(7, 0));
    pend_wd[r] = $urandom;
  endtask

  function automatic int pick_model();
    for (int k = 0; k < NREQ; k++)
      if (pend_v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  function automatic int rand_dly();
    int s;
    s = $urandom_range(19, 0);
    if (s < 15) return s % 6;
    if (s < 19) return $urandom_range(20, 6);
    return -1;
  endfunction

  // Entered just after a posedge with the DUT idle; dly<0 = never acked.
  // mode: 0 drop granted request, 1 keep it, 2 replace it randomly.
  task automatic do_txn(input string tag, input int dly, input int mode);
    int w, idx, rsp_at;
    bit we, err, ok;
    logic [DW-1:0] exp_rd, exp_wd;
    if (pend_v == '0) begin
      drive_reqs();
      drive_ip(-1, 1'b0, 1'b0);
      @(negedge clk);
      check_eq({tag, "_idle"}, 64'(bus.req_ready_o), 64'(0));
      @(posedge clk); #1;
      pend_v[$urandom_range(NREQ-1, 0)] = 1'b1;
    end
    w = pick_model();
    ptr_m = (w + 1) % NREQ;
    we = pend_we[w];
    idx = int'(pend_idx[w]);
    exp_wd = pend_wd[w];
    ok = (idx < NREG);
    if (!ok) begin
      err = 1'b1; rsp_at = 2;
    end else if (dly >= 0 && dly <= TIMEOUT) begin
      err = 1'b0; rsp_at = dly + 2;
    end else begin
      err = 1'b1; rsp_at = TIMEOUT + 2;
    end
    exp_rd = (err || we) ? '0 : ipd[idx];
    for (int c = 0; c <= rsp_at; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c == 1) begin
        if (mode == 0) pend_v[w] = 1'b0;
        else if (mode == 2) regen(w);
      end
      drive_reqs();
      drive_ip(idx, we, ok && dly >= 0 && c >= dly + 1);
      @(negedge clk);
      check_eq({tag, "_rdy"}, 64'(bus.req_ready_o),
               c == 0 ? 64'(1) << w : 64'(0));
      check_eq({tag, "_wen"}, 64'(bus.ip_wen_o),
               (c == 1 && we && ok) ? 64'(1) << idx : 64'(0));
      if (we && ok && c >= 1 && c < rsp_at)
        check_eq({tag, "_wdata"}, 64'(bus.ip_wdata_o), 64'(exp_wd));
      check_eq({tag, "_rsp"}, 64'(bus.rsp_valid_o),
               c == rsp_at ? 64'(1) << w : 64'(0));
      if (c == rsp_at) begin
        check_eq({tag, "_err"}, 64'(bus.rsp_err_o), 64'(err));
        check_eq({tag, "_rdata"}, 64'(bus.rsp_rdata_o), 64'(exp_rd));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rdy"}, 64'(bus.req_ready_o), 64'(0));
    check_eq({tag, "_rsp"}, 64'(bus.rsp_valid_o), 64'(0));
    check_eq({tag, "_rdata"}, 64'(bus.rsp_rdata_o), 64'(0));
    check_eq({tag, "_err"}, 64'(bus.rsp_err_o), 64'(0));
    check_eq({tag, "_wen"}, 64'(bus.ip_wen_o), 64'(0));
    check_eq({tag, "_wdata"}, 64'(bus.ip_wdata_o), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ptr_m = 0;
    pend_v = '0;
    for (int r = 0; r < NREQ; r++) begin
      pend_we[r] = 1'b0;
      pend_idx[r] = '0;
      pend_wd[r] = '0;
    end
    for (int i = 0; i < NREG; i++) ipd[i] = $urandom;
    ipd[4] = 32'h369C;
    ipd[5] = 32'h48D0;
    rst_i = 1'b1;
    drive_reqs();
    drive_ip(-1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    // reset lands while a read of idx 1 is stuck in WAIT
    pend_v[1] = 1'b1; pend_we[1] = 1'b0; pend_idx[1] = 3'd1;
    drive_reqs();
    drive_ip(1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("mw_rdy", 64'(bus.req_ready_o), 64'(3'b010));
    @(posedge clk); #1;
    pend_v[1] = 1'b0;
    drive_reqs();
    drive_ip(1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("mw_rsp", 64'(bus.rsp_valid_o), 64'(0));
      @(posedge clk); #1;
      drive_ip(1, 1'b0, 1'b0);
    end
    rst_i = 1'b1;
    drive_ip(1, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    ptr_m = 0;
    @(negedge clk);
    check_quiet("mw_after");
    @(posedge clk); #1;
    pend_v[0] = 1'b1; pend_we[0] = 1'b0; pend_idx[0] = 3'd2;
    pend_v[2] = 1'b1; pend_we[2] = 1'b0; pend_idx[2] = 3'd3;
    do_txn("mw_next0", 0, 0);
    do_txn("mw_next2", 0, 0);

    // all three read back-to-back, rvalid immediately high
    for (int r = 0; r < NREQ; r++) begin
      pend_v[r] = 1'b1; pend_we[r] = 1'b0;
    end
    pend_idx[0] = 3'd4; pend_idx[1] = 3'd0; pend_idx[2] = 3'd3;
    for (int n = 0; n < 6; n++) do_txn("rr", 0, 1);
    pend_v = '0;

    pend_v[1] = 1'b1; pend_we[1] = 1'b1;
    pend_idx[1] = 3'd2; pend_wd[1] = 32'h2468;
    do_txn("wr_fast", 0, 0);

    pend_v[0] = 1'b1; pend_we[0] = 1'b0; pend_idx[0] = 3'd5;
    do_txn("rd_slow", 10, 0);

    pend_v[2] = 1'b1; pend_we[2] = 1'b1;
    pend_idx[2] = 3'd0; pend_wd[2] = 32'hCAFE_0001;
    do_txn("wr_tmo", -1, 0);
`ifdef CUSTOM_IP_SCHED_STATS_EN
    check_eq("stat_tmo", 64'(stat_timeout), 64'(1));
`endif

    pend_v[0] = 1'b1; pend_we[0] = 1'b0; pend_idx[0] = 3'd7;
    do_txn("rd_badidx", 0, 0);
    pend_v[1] = 1'b1; pend_we[1] = 1'b1;
    pend_idx[1] = 3'd6; pend_wd[1] = 32'h1;
    do_txn("wr_badidx", 0, 0);

    // ack on the final wait cycle beats the timeout; one later loses
    pend_v[2] = 1'b1; pend_we[2] = 1'b0; pend_idx[2] = 3'd3;
    do_txn("rd_edge64", TIMEOUT, 0);
    pend_v[0] = 1'b1; pend_we[0] = 1'b1;
    pend_idx[0] = 3'd1; pend_wd[0] = 32'h55AA;
    do_txn("wr_edge65", TIMEOUT + 1, 0);

    for (int r = 0; r < NREQ; r++) regen(r);
    for (int n = 0; n < 60; n++) do_txn("rand", rand_dly(), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/custom_ip_reg_sched.md
Name: custom_ip_reg_sched

Overview:
Round-robin scheduler that shares the custom IP's register channel between NREQ requesters, e.g. the core, the debug bridge and a DMA.
- Serialises register accesses: one transaction in flight at a time.
- Writes drive the IP's per-register write-enable/data lines and wait for a per-register acknowledge.
- Reads wait for the IP's per-register data-valid flag.
- Each transaction returns a one-cycle response to its requester, with an error flag on timeout or a bad register index.

Parameters:
NREQ, 3, number of requesters (2..8)
NREG, 6, number of IP registers addressable
DW, 32, register data width
IDXW, 3, register index width (must satisfy 2**IDXW >= NREG)
TIMEOUT, 64, cycles to wait for IP ack/valid; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NREQ  per-requester request valid
req_ready_o  out  NREQ  per-requester accept, one-hot or zero
req_we_i  in  NREQ  1=write, 0=read
req_idx_i  in  NREQ*IDXW  register index, requester r at [r*IDXW +: IDXW]
req_wdata_i  in  NREQ*DW  write data per requester
rsp_valid_o  out  NREQ  one-cycle response pulse to the owning requester
rsp_rdata_o  out  DW  read data, shared, valid with rsp_valid_o
rsp_err_o  out  1  error flag, valid with rsp_valid_o
ip_wen_o  out  NREG  one-cycle write-enable pulse to the IP
ip_wdata_o  out  DW  write data to the IP, shared across registers
ip_wack_i  in  NREG  write acknowledge from the IP
ip_rdata_i  in  NREG*DW  IP read data per register
ip_rvalid_i  in  NREG  IP data-ready flag per register

Behaviour:
- Reset values (rst_i sampled high at a clk_i edge):
  - state=IDLE; rr pointer=0, so requester 0 has highest priority; timeout counter=0.
  - All outputs 0: req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ip_wen_o, ip_wdata_o.
  - A transaction in flight when reset is sampled is dropped; no response is issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first r with req_valid_i[r]=1, searching from the rr pointer upward with wrap.
  - req_ready_o[winner]=1 combinationally while in IDLE. The handshake completes that cycle.
  - On the handshake: latch requester id, we, idx, wdata; rr pointer <= winner+1 mod NREQ; go to ISSUE.
  - With no valid request: stay in IDLE, req_ready_o=0.
- ISSUE (1 cycle):
  - If idx >= NREG: no IP access; set err=1, rdata=0; go to RESP.
  - Write: ip_wen_o[idx]=1 for exactly this cycle; ip_wdata_o=latched wdata, held through WAIT. If ip_wack_i[idx]=1 this same cycle, go to RESP, else go to WAIT.
  - Read: if ip_rvalid_i[idx]=1, capture ip_rdata_i[idx] and go to RESP, else go to WAIT.
  - Timeout counter cleared on leaving ISSUE.
- WAIT:
  - Write: wait for ip_wack_i[idx]. Read: wait for ip_rvalid_i[idx], capturing data on that cycle.
  - The counter increments each WAIT cycle.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack/valid: err=1, rdata=0, go to RESP.
  - If ack/valid and timeout occur in the same cycle, ack/valid wins (err=0).
  - Ack/valid bits for other indices are ignored.
- RESP (1 cycle):
  - rsp_valid_o[owner]=1; rsp_rdata_o and rsp_err_o valid this cycle only.
  - rsp_rdata_o=0 for writes.
  - Next state IDLE. No acceptance happens in RESP.
- Latency:
  - Read with rvalid already high: accept at cycle 0, response at cycle 2.
  - Write with ack in the ISSUE cycle: response at cycle 2.
  - Throughput: at most one transaction per 3 cycles.
- Requesters must hold req_* stable until ready. A requester dropping valid before ready is legal and is simply not granted.

Optional Feature:
CUSTOM_IP_SCHED_STATS_EN
- Defined: adds two output ports.
  - stat_busy_o [31:0]: counts cycles with state!=IDLE.
  - stat_timeout_o [15:0]: counts timeout errors.
  - Both saturate at all-ones and are cleared by rst_i.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-WAIT (read of idx 1, rvalid low, rst_i high one cycle) -> rsp_valid_o never pulses; all outputs 0 the next cycle; the next request from requester 0 is granted first.
- Requester 1 writes idx 2 data 0x2468, IP acks in the ISSUE cycle -> ip_wen_o=6'b000100 for exactly 1 cycle with ip_wdata_o=0x2468; rsp_valid_o=3'b010 at cycle 2; rsp_err_o=0.
- Requesters 0, 1, 2 all read continuously, rvalid tied high -> grant order 0,1,2,0,1,2; each rsp_rdata_o equals the matching ip_rdata_i (e.g. idx 4 returns 0x369C).
- Read idx 5, rvalid arrives after 10 cycles with data 0x48D0 -> response 12 cycles after accept, rdata=0x48D0, err=0.
- Write idx 0 with TIMEOUT=64, ack never asserted -> rsp_err_o=1 and rdata=0 after 64 WAIT cycles; stat_timeout_o=1 when the macro is defined.
- Read idx 7 with NREG=6 -> ip_wen_o stays 0; rsp_err_o=1 at cycle 2.
